// File: rtl/lutram_fifo_ctrl.sv
// lutram_fifo_ctrl
// Sequencing controller that turns an external 16x4 distributed LUT RAM
// (synchronous write, asynchronous read) into a first-word-fall-through FIFO.
// Words live in the RAM until a registered output stage pulls them.
// LEVEL counts the RAM words plus the output stage, so it can reach 17.
module lutram_fifo_ctrl #(
    parameter int unsigned AF_THR = 12,
    parameter int unsigned AE_THR = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       FLUSH,
    input  logic       S_VALID,
    output logic       S_READY,
    input  logic [3:0] S_DATA,
    output logic       M_VALID,
    input  logic       M_READY,
    output logic [3:0] M_DATA,
    output logic       RAM_WRE,
    output logic [3:0] RAM_WAD,
    output logic [3:0] RAM_DI,
    output logic [3:0] RAM_RAD,
    input  logic [3:0] RAM_DO,
    output logic [4:0] LEVEL,
    output logic       ALMOST_FULL,
    output logic       ALMOST_EMPTY
);

    localparam logic [5:0] AF_LIM = 6'(AF_THR);
    localparam logic [5:0] AE_LIM = 6'(AE_THR);

    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [4:0] ram_cnt;
    logic [4:0] ram_cnt_next;
    logic       out_vld;
    logic       s_rdy;
    logic [3:0] m_data_q;
    logic       push;
    logic       pop;
    logic       load;

    // Handshake decode and next-count; every term uses pre-edge register values
    always_comb begin
        push         = S_VALID && s_rdy;
        pop          = out_vld && M_READY;
        load         = (!out_vld || M_READY) && (ram_cnt != 5'd0);
        ram_cnt_next = ram_cnt + {4'd0, push} - {4'd0, load};
    end

    // RAM side: write at wr_ptr on push, read address always follows rd_ptr
    always_comb begin
        RAM_WRE = push;
        RAM_WAD = wr_ptr;
        RAM_DI  = S_DATA;
        RAM_RAD = rd_ptr;
    end

    // Pointers, occupancy, output-valid and registered ready
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            out_vld <= 1'b0;
            s_rdy   <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            out_vld <= 1'b0;
            s_rdy   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (load) begin
                rd_ptr  <= rd_ptr + 4'd1;
                out_vld <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            ram_cnt <= ram_cnt_next;
            // ready depends only on registered state, never on M_READY directly
            s_rdy   <= (ram_cnt_next < 5'd16);
        end
    end

    // Output data register: captures the asynchronous RAM read on load, holds otherwise
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_data_q <= '0;
        end else if (!FLUSH && load) begin
            m_data_q <= RAM_DO;
        end
    end

    // Level and threshold flags derived from registered state
    always_comb begin
        LEVEL        = ram_cnt + {4'd0, out_vld};
        ALMOST_FULL  = ({1'b0, LEVEL} >= AF_LIM);
        ALMOST_EMPTY = ({1'b0, LEVEL} <= AE_LIM);
        S_READY      = s_rdy;
        M_VALID      = out_vld;
        M_DATA       = m_data_q;
    end

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Directed bench for lutram_fifo_ctrl with a behavioural 16x4 LUT RAM beside it.
module tb_lutram_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       FLUSH;
    logic       S_VALID;
    logic       S_READY;
    logic [3:0] S_DATA;
    logic       M_VALID;
    logic       M_READY;
    logic [3:0] M_DATA;
    logic       RAM_WRE;
    logic [3:0] RAM_WAD;
    logic [3:0] RAM_DI;
    logic [3:0] RAM_RAD;
    logic [3:0] RAM_DO;
    logic [4:0] LEVEL;
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;

    logic [3:0] mem [16];
    logic [3:0] sb [$];
    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    // Distributed RAM model: synchronous write, asynchronous read
    always @(posedge CLK) if (RAM_WRE) mem[RAM_WAD] <= RAM_DI;
    assign RAM_DO = mem[RAM_RAD];

    lutram_fifo_ctrl #(.AF_THR(12), .AE_THR(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .RAM_WRE(RAM_WRE), .RAM_WAD(RAM_WAD), .RAM_DI(RAM_DI),
        .RAM_RAD(RAM_RAD), .RAM_DO(RAM_DO), .LEVEL(LEVEL),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One clock with given inputs; scoreboard tracks held words, so LEVEL == sb.size()
    task automatic cyc(input logic sv, input logic [3:0] sd, input logic mr,
                       output logic pushed, output logic popped);
        int sz;
        S_VALID = sv;
        S_DATA  = sd;
        M_READY = mr;
        #1;
        pushed = sv && S_READY;
        popped = M_VALID && mr;
        if (popped) begin
            if (sb.size() == 0) check("pop_underflow", 32'(M_VALID), 32'd0);
            else begin
                check("pop_data", 32'(M_DATA), 32'(sb[0]));
                void'(sb.pop_front());
            end
        end
        if (pushed) sb.push_back(sd);
        tick();
        sz = sb.size();
        check("level", 32'(LEVEL), 32'(sz));
        check("almost_full", 32'(ALMOST_FULL), 32'(sz >= 12));
        check("almost_empty", 32'(ALMOST_EMPTY), 32'(sz <= 4));
        if (sz > 17) check("level_bound", 32'(sz), 32'd17);
    endtask

    initial begin
        logic p, q;
        logic [3:0] wd;
        int tx, rx, guard;

        RESETN = 1'b0; FLUSH = 1'b0; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;

        // Reset state held across a few edges
        repeat (3) tick();
        check("rst_s_ready", 32'(S_READY), 32'd0);
        check("rst_m_valid", 32'(M_VALID), 32'd0);
        check("rst_m_data", 32'(M_DATA), 32'd0);
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_af", 32'(ALMOST_FULL), 32'd0);
        check("rst_ae", 32'(ALMOST_EMPTY), 32'd1);
        RESETN = 1'b1;
        #1;
        check("rel_s_ready_pre", 32'(S_READY), 32'd0);
        tick();
        check("rel_s_ready", 32'(S_READY), 32'd1);

        // Single write of 4'hA, FWFT latency of one extra edge
        S_VALID = 1'b1; S_DATA = 4'hA;
        #1;
        check("wr_wre", 32'(RAM_WRE), 32'd1);
        check("wr_wad", 32'(RAM_WAD), 32'd0);
        check("wr_di", 32'(RAM_DI), 32'hA);
        cyc(1'b1, 4'hA, 1'b0, p, q);
        check("wr_accepted", 32'(p), 32'd1);
        check("e_m_valid", 32'(M_VALID), 32'd0);
        cyc(1'b0, 4'h0, 1'b0, p, q);
        check("e1_m_valid", 32'(M_VALID), 32'd1);
        check("e1_m_data", 32'(M_DATA), 32'hA);
        cyc(1'b0, 4'h0, 1'b1, p, q);
        check("pop_m_valid", 32'(M_VALID), 32'd0);
        check("idle_wre", 32'(RAM_WRE), 32'd0);

        // Fill 0..F,0 with consumer stalled: exactly 17 accepted
        for (int i = 0; i < 17; i++) begin
            check("fill_rdy", 32'(S_READY), 32'd1);
            cyc(1'b1, 4'(i), 1'b0, p, q);
        end
        check("full_s_ready", 32'(S_READY), 32'd0);
        check("full_level", 32'(LEVEL), 32'd17);
        check("full_af", 32'(ALMOST_FULL), 32'd1);
        check("full_m_data", 32'(M_DATA), 32'h0);
        cyc(1'b1, 4'h1, 1'b0, p, q);
        check("full_reject", 32'(p), 32'd0);

        // Drain from full with writer always offering; first pop frees RAM, ready returns
        wd = 4'h1;
        cyc(1'b1, wd, 1'b1, p, q);
        check("drain_first_push", 32'(p), 32'd0);
        check("drain_rdy_back", 32'(S_READY), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, wd, 1'b1, p, q);
            if (p) wd = wd + 4'd1;
        end
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            cyc(1'b0, 4'h0, 1'b1, p, q);
            guard++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);

        // Random handshakes: 40 incrementing words through several pointer wraps
        tx = 0; rx = 0; guard = 0;
        while (rx < 40 && guard < 3000) begin
            cyc((tx < 40) && ($urandom_range(0, 1) == 1), 4'(tx), ($urandom_range(0, 2) != 0), p, q);
            if (p) tx++;
            if (q) rx++;
            guard++;
        end
        check("stream_rx", 32'(rx), 32'd40);

        // Flush at LEVEL 9, with a push and pop offered in the flush cycle
        for (int i = 0; i < 9; i++) cyc(1'b1, 4'(i + 3), 1'b0, p, q);
        check("pre_flush_level", 32'(LEVEL), 32'd9);
        FLUSH = 1'b1; S_VALID = 1'b1; M_READY = 1'b1;
        tick();
        sb.delete();
        FLUSH = 1'b0; S_VALID = 1'b0; M_READY = 1'b0;
        check("flush_level", 32'(LEVEL), 32'd0);
        check("flush_m_valid", 32'(M_VALID), 32'd0);
        check("flush_s_ready", 32'(S_READY), 32'd0);
        tick();
        check("post_flush_rdy", 32'(S_READY), 32'd1);
        cyc(1'b1, 4'h5, 1'b0, p, q);
        cyc(1'b0, 4'h0, 1'b0, p, q);
        check("flush_new_valid", 32'(M_VALID), 32'd1);
        check("flush_new_data", 32'(M_DATA), 32'h5);
        cyc(1'b0, 4'h0, 1'b1, p, q);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 8), 1'b0, p, q);
        #2;
        RESETN = 1'b0;
        #1;
        sb.delete();
        check("arst_level", 32'(LEVEL), 32'd0);
        check("arst_m_valid", 32'(M_VALID), 32'd0);
        check("arst_s_ready", 32'(S_READY), 32'd0);
        check("arst_m_data", 32'(M_DATA), 32'd0);
        check("arst_ae", 32'(ALMOST_EMPTY), 32'd1);
        S_VALID = 1'b0;
        tick();
        RESETN = 1'b1;
        tick();
        check("arst_rel_rdy", 32'(S_READY), 32'd1);
        cyc(1'b1, 4'hC, 1'b0, p, q);
        cyc(1'b0, 4'h0, 1'b0, p, q);
        check("arst_new_data", 32'(M_DATA), 32'hC);
        cyc(1'b0, 4'h0, 1'b1, p, q);
        check("arst_final_valid", 32'(M_VALID), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
